// File: rtl/floo_pkg.sv
// Shared types for the floo router slice.
package floo_pkg;

  typedef enum logic [0:0] {
    SaIdle   = 1'b0,
    SaLocked = 1'b1
  } sa_state_e;

endpackage

// File: rtl/floo_credit_counter.sv
// Per-VC downstream credit counters with saturating, sticky-error returns.
module floo_credit_counter #(
  parameter int unsigned NumVC       = 4,
  parameter int unsigned VCDepth     = 3,
  parameter int unsigned CreditWidth = $clog2(VCDepth + 1)
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [NumVC-1:0]                    dec_i,
  input  logic [NumVC-1:0]                    inc_i,
  output logic [NumVC-1:0][CreditWidth-1:0]   count_o,
  output logic [NumVC-1:0]                    avail_o,
  output logic                                err_o
);

  localparam logic [CreditWidth-1:0] Full = CreditWidth'(VCDepth);

  logic [NumVC-1:0][CreditWidth-1:0] cnt_q;
  logic                              err_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int unsigned v = 0; v < NumVC; v++) cnt_q[v] <= Full;
      err_q <= 1'b0;
    end else begin
      for (int unsigned v = 0; v < NumVC; v++) begin
        if (inc_i[v] && !dec_i[v]) begin
          if (cnt_q[v] == Full) err_q <= 1'b1;
          else                  cnt_q[v] <= cnt_q[v] + 1'b1;
        end else if (dec_i[v] && !inc_i[v]) begin
          cnt_q[v] <= cnt_q[v] - 1'b1;
        end
      end
    end
  end

  always_comb begin
    for (int unsigned v = 0; v < NumVC; v++) avail_o[v] = (cnt_q[v] != '0);
  end

  assign count_o = cnt_q;
  assign err_o   = err_q;

endmodule

// File: rtl/floo_rr_arbiter.sv
// Round-robin arbiter; pointer moves to winner+1 only when update_i is set.
module floo_rr_arbiter #(
  parameter int unsigned NumReq   = 5,
  parameter int unsigned IdxWidth = NumReq > 1 ? $clog2(NumReq) : 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NumReq-1:0]   req_i,
  input  logic                update_i,
  output logic [NumReq-1:0]   gnt_oh_o,
  output logic [IdxWidth-1:0] gnt_idx_o,
  output logic                gnt_v_o
);

  logic [IdxWidth-1:0] ptr_q;

  always_comb begin
    int unsigned         idx;
    logic [IdxWidth-1:0] idx_t;
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    gnt_v_o   = 1'b0;
    idx       = 0;
    idx_t     = '0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      idx   = (32'(ptr_q) + k) % NumReq;
      idx_t = IdxWidth'(idx);
      if (!gnt_v_o && req_i[idx_t]) begin
        gnt_v_o         = 1'b1;
        gnt_oh_o[idx_t] = 1'b1;
        gnt_idx_o       = idx_t;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else if (update_i && gnt_v_o) begin
      ptr_q <= (gnt_idx_o == IdxWidth'(NumReq - 1)) ? '0 : gnt_idx_o + 1'b1;
    end
  end

endmodule

// File: rtl/floo_sa_global_ctrl.sv
// Second-stage switch allocator for one output port: credit-gated round-robin
// with wormhole locking and a registered crossbar select.
module floo_sa_global_ctrl
  import floo_pkg::*;
#(
  parameter int unsigned NumInputs      = 5,
  parameter int unsigned NumVC          = 4,
  parameter int unsigned NumVCWidth     = NumVC > 1 ? $clog2(NumVC) : 1,
  parameter int unsigned NumInputsWidth = NumInputs > 1 ? $clog2(NumInputs) : 1,
  parameter int unsigned VCDepth        = 3,
  parameter int unsigned CreditWidth    = $clog2(VCDepth + 1)
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic [NumInputs-1:0]                  req_v_i,
  input  logic [NumInputs-1:0][NumVCWidth-1:0]  req_vc_i,
  input  logic [NumInputs-1:0]                  req_last_i,
  output logic [NumInputs-1:0]                  grant_oh_o,
  output logic                                  grant_v_o,
  output logic [NumInputs-1:0]                  update_rr_arb_o,
  input  logic                                  credit_v_i,
  input  logic [NumVCWidth-1:0]                 credit_vc_i,
  output logic [NumVC-1:0]                      credit_avail_o,
  output logic                                  st_v_o,
  output logic [NumInputsWidth-1:0]             st_sel_o,
  output logic [NumVCWidth-1:0]                 st_vc_o,
  output logic                                  credit_err_o
);

  sa_state_e                         state_q;
  logic [NumInputsWidth-1:0]         lock_id_q;
  logic [NumVCWidth-1:0]             lock_vc_q;
  logic [NumVC-1:0][CreditWidth-1:0] cnt;
  logic [NumVC-1:0]                  dec, inc;
  logic [NumInputs-1:0]              elig, arb_req;
  logic [NumInputsWidth-1:0]         gnt_idx;
  logic [NumVCWidth-1:0]             gnt_vc;

  // While locked the arbiter sees only the lock owner, so its tail-flit update
  // lands the pointer on lock_id+1 without a separate pointer path.
  always_comb begin
    elig    = '0;
    arb_req = '0;
    for (int unsigned i = 0; i < NumInputs; i++) begin
      elig[i] = req_v_i[i] && (cnt[req_vc_i[i]] != '0);
    end
    if (rst_ni) begin
      if (state_q == SaIdle) begin
        arb_req = elig;
      end else begin
        arb_req[lock_id_q] = req_v_i[lock_id_q] && (cnt[lock_vc_q] != '0);
      end
    end
  end

  floo_rr_arbiter #(
    .NumReq   (NumInputs),
    .IdxWidth (NumInputsWidth)
  ) i_rr_arbiter (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .req_i     (arb_req),
    .update_i  (|update_rr_arb_o),
    .gnt_oh_o  (grant_oh_o),
    .gnt_idx_o (gnt_idx),
    .gnt_v_o   (grant_v_o)
  );

  assign update_rr_arb_o = grant_oh_o & req_last_i;
  assign gnt_vc          = (state_q == SaLocked) ? lock_vc_q : req_vc_i[gnt_idx];

  always_comb begin
    dec = '0;
    inc = '0;
    for (int unsigned v = 0; v < NumVC; v++) begin
      dec[v] = grant_v_o  && (gnt_vc == NumVCWidth'(v));
      inc[v] = credit_v_i && (credit_vc_i == NumVCWidth'(v));
    end
  end

  floo_credit_counter #(
    .NumVC       (NumVC),
    .VCDepth     (VCDepth),
    .CreditWidth (CreditWidth)
  ) i_credit_counter (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .dec_i   (dec),
    .inc_i   (inc),
    .count_o (cnt),
    .avail_o (credit_avail_o),
    .err_o   (credit_err_o)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= SaIdle;
      lock_id_q <= '0;
      lock_vc_q <= '0;
    end else begin
      unique case (state_q)
        SaIdle: begin
          if (grant_v_o && !req_last_i[gnt_idx]) begin
            state_q   <= SaLocked;
            lock_id_q <= gnt_idx;
            lock_vc_q <= req_vc_i[gnt_idx];
          end
        end
        SaLocked: begin
          if (grant_v_o && req_last_i[lock_id_q]) state_q <= SaIdle;
        end
        default: state_q <= SaIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      st_v_o   <= 1'b0;
      st_sel_o <= '0;
      st_vc_o  <= '0;
    end else begin
      st_v_o <= grant_v_o;
      if (grant_v_o) begin
        st_sel_o <= gnt_idx;
        st_vc_o  <= gnt_vc;
      end
    end
  end

  a_locked_vc_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_q == SaLocked && req_v_i[lock_id_q]) |-> (req_vc_i[lock_id_q] == lock_vc_q));

endmodule

// File: tb/tb_floo_sa_global_ctrl.sv
// Scoreboard bench: reference model predicts grants, credits and ST outputs.
module tb_floo_sa_global_ctrl;

  localparam int N = 5;
  localparam int V = 4;
  localparam int D = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N-1:0]      req_v = '0;
  logic [N-1:0][1:0] req_vc = '0;
  logic [N-1:0]      req_last = '0;
  logic              credit_v = 1'b0;
  logic [1:0]        credit_vc = '0;
  logic [N-1:0]      grant_oh, update_rr;
  logic              grant_v, st_v, credit_err;
  logic [V-1:0]      credit_avail;
  logic [2:0]        st_sel;
  logic [1:0]        st_vc;

  always #5 clk = ~clk;

  floo_sa_global_ctrl #(
    .NumInputs (N),
    .NumVC     (V),
    .VCDepth   (D)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .req_v_i         (req_v),
    .req_vc_i        (req_vc),
    .req_last_i      (req_last),
    .grant_oh_o      (grant_oh),
    .grant_v_o       (grant_v),
    .update_rr_arb_o (update_rr),
    .credit_v_i      (credit_v),
    .credit_vc_i     (credit_vc),
    .credit_avail_o  (credit_avail),
    .st_v_o          (st_v),
    .st_sel_o        (st_sel),
    .st_vc_o         (st_vc),
    .credit_err_o    (credit_err)
  );

  typedef struct {
    logic [N-1:0] goh;
    logic         gv;
    logic [N-1:0] upd;
    logic [V-1:0] avail;
    logic         err;
  } comb_t;

  typedef struct {
    logic       v;
    logic [2:0] sel;
    logic [1:0] vc;
  } st_t;

  comb_t comb_q[$];
  st_t   st_q[$];
  int    compared = 0;
  int    mismatched = 0;

  // Reference model state
  int cred[V] = '{D, D, D, D};
  bit m_locked = 0;
  int m_lock_id = 0, m_lock_vc = 0, m_ptr = 0;
  bit m_err = 0;
  int m_sel = 0, m_vc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic rst_val, input logic [N-1:0] rv, input logic [N-1:0][1:0] vcv,
                      input logic [N-1:0] last, input logic cv, input logic [1:0] cvc);
    comb_t ec;
    st_t   es;
    int    w, gvc, idx;
    bit    d, i;
    @(negedge clk);
    rst_n = rst_val; req_v = rv; req_vc = vcv; req_last = last;
    credit_v = cv; credit_vc = cvc;

    for (int v = 0; v < V; v++) ec.avail[v] = (cred[v] != 0);
    ec.err = m_err;
    w = -1;
    gvc = 0;
    if (rst_val) begin
      if (m_locked) begin
        if (rv[m_lock_id] && cred[m_lock_vc] > 0) w = m_lock_id;
        gvc = m_lock_vc;
      end else begin
        for (int k = 0; k < N; k++) begin
          idx = (m_ptr + k) % N;
          if (w < 0 && rv[idx] && cred[vcv[idx]] > 0) w = idx;
        end
        if (w >= 0) gvc = int'(vcv[w]);
      end
    end
    ec.goh = '0;
    ec.upd = '0;
    ec.gv  = (w >= 0);
    if (w >= 0) begin
      ec.goh[w] = 1'b1;
      ec.upd[w] = last[w];
    end
    comb_q.push_back(ec);

    if (!rst_val) begin
      foreach (cred[v]) cred[v] = D;
      m_locked = 0; m_ptr = 0; m_err = 0; m_sel = 0; m_vc = 0;
      es.v = 1'b0;
    end else begin
      for (int v = 0; v < V; v++) begin
        d = (w >= 0) && (gvc == v);
        i = cv && (int'(cvc) == v);
        if (d && !i) cred[v]--;
        else if (i && !d) begin
          if (cred[v] == D) m_err = 1;
          else cred[v]++;
        end
      end
      if (w >= 0) begin
        if (last[w]) begin
          m_ptr = (w + 1) % N;
          m_locked = 0;
        end else if (!m_locked) begin
          m_locked = 1; m_lock_id = w; m_lock_vc = gvc;
        end
        m_sel = w; m_vc = gvc;
      end
      es.v = (w >= 0);
    end
    es.sel = 3'(m_sel);
    es.vc  = 2'(m_vc);
    st_q.push_back(es);
  endtask

  initial begin : comb_monitor
    comb_t e;
    forever begin
      @(negedge clk);
      #2;
      if (comb_q.size() > 0) begin
        e = comb_q.pop_front();
        check("grant_oh", 32'(grant_oh), 32'(e.goh));
        check("grant_v", 32'(grant_v), 32'(e.gv));
        check("update_rr_arb", 32'(update_rr), 32'(e.upd));
        check("credit_avail", 32'(credit_avail), 32'(e.avail));
        check("credit_err", 32'(credit_err), 32'(e.err));
      end
    end
  end

  initial begin : st_monitor
    st_t e;
    forever begin
      @(posedge clk);
      #1;
      if (st_q.size() > 0) begin
        e = st_q.pop_front();
        check("st_v", 32'(st_v), 32'(e.v));
        check("st_sel", 32'(st_sel), 32'(e.sel));
        check("st_vc", 32'(st_vc), 32'(e.vc));
      end
    end
  end

  initial begin
    logic [N-1:0][1:0] vcv;
    logic [N-1:0]      rv, last;
    logic              rst_val;

    step(0, '0, '0, '0, 0, 0);
    step(0, '0, '0, '0, 0, 0);

    // Two single-flit requesters on VC0
    step(1, 5'b00110, '0, '1, 0, 0);
    step(1, 5'b00110, '0, '1, 0, 0);
    step(1, '0, '0, '0, 1, 0);
    step(1, '0, '0, '0, 1, 0);

    // Input 0: 3-flit packet on VC1; input 3 competing on VC2
    vcv = '0; vcv[0] = 2'd1; vcv[3] = 2'd2;
    for (int f = 0; f < 5; f++) begin
      last = 5'b01000;
      if (f == 3) last[0] = 1'b1;
      step(1, 5'b01001, vcv, last, 0, 0);
    end
    step(1, 5'b01000, vcv, 5'b01000, 0, 0);
    for (int c = 0; c < 3; c++) step(1, '0, '0, '0, 1, 2'(c + 1));
    step(1, '0, '0, '0, 1, 2);

    // Exhaust VC2 credits from input 4, then return one
    vcv = '0; vcv[4] = 2'd2;
    for (int f = 0; f < 4; f++) step(1, 5'b10000, vcv, '1, 0, 0);
    step(1, 5'b10000, vcv, '1, 1, 2);
    step(1, 5'b10000, vcv, '1, 0, 0);
    for (int c = 0; c < 4; c++) step(1, '0, '0, '0, 1, 2);

    // Grant on VC0 with same-cycle credit on VC0
    vcv = '0;
    step(1, 5'b10000, vcv, '1, 0, 0);
    step(1, 5'b10000, vcv, '1, 1, 0);
    step(1, '0, '0, '0, 0, 0);

    // Credit on a full VC3 counter: sticky error
    step(1, '0, '0, '0, 1, 3);
    step(1, '0, '0, '0, 0, 0);
    step(1, '0, '0, '0, 0, 0);

    // Reset mid-packet, then a new requester
    vcv = '0; vcv[1] = 2'd1;
    step(1, 5'b00010, vcv, '0, 0, 0);
    step(0, 5'b00010, vcv, '0, 0, 0);
    vcv = '0; vcv[2] = 2'd3;
    step(1, 5'b00100, vcv, '1, 0, 0);
    step(1, '0, '0, '0, 0, 0);

    // Randomised traffic, credit returns and occasional resets
    for (int n = 0; n < 600; n++) begin
      rv   = N'($urandom);
      last = N'($urandom);
      for (int k = 0; k < N; k++) vcv[k] = 2'($urandom_range(0, V - 1));
      if (m_locked) vcv[m_lock_id] = 2'(m_lock_vc);
      rst_val = ($urandom_range(0, 59) != 0);
      step(rst_val, rv, vcv, last, ($urandom_range(0, 9) < 4), 2'($urandom_range(0, V - 1)));
    end

    step(1, '0, '0, '0, 0, 0);
    step(1, '0, '0, '0, 0, 0);
    @(negedge clk);
    #4;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
